brick_field_engine: RTL and testbench

Parametrised, fully synchronous brick-wall engine for the ball-and-paddle game family. It stores a BRICKS_H × BRICKS_V brick field and generates the brick video signal from the beam position. It detects ball/brick pixel collisions, with at most one hit per frame. Each brick has a strength counter, and the engine refills the wall automatically when the last brick dies. It sits between hvsync_generator and the top-level playfield mux; its hit strobe feeds player_stats.

---
 rtl/brick_pkg.sv | 34 +++
 rtl/brick_store.sv | 49 ++++
 rtl/brick_field_engine.sv | 198 +++++++++++++++++++
 tb/tb_brick_field_engine.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// brick_pkg: shared types and helpers for the brick field engine.
//   state_e        - engine state (fill sweep, play, waiting for refill after clear)
//   STRENGTH_W     - bits per brick strength counter
//   init_strength  - starting strength of a brick, by row
// Configuration macro: BRICK_MULTIHIT_EN (2-bit strength, tiered by row) when defined;
// otherwise 1-bit strength and every hit kills.
package brick_pkg;

  typedef enum logic [1:0] {StFill, StPlay, StCleared} state_e;

`ifdef BRICK_MULTIHIT_EN
  localparam int unsigned STRENGTH_W = 2;
`else
  localparam int unsigned STRENGTH_W = 1;
`endif

  function automatic logic [STRENGTH_W-1:0] init_strength(input int unsigned row);
    logic [1:0] tiered;
    if (row == 0) begin
      tiered = 2'd3;
    end else if (row < 3) begin
      tiered = 2'd2;
    end else begin
      tiered = 2'd1;
    end
`ifdef BRICK_MULTIHIT_EN
    return tiered;
`else
    // Single-hit bricks all start alive regardless of row.
    return |tiered;
`endif
  endfunction

endpackage

// File: rtl/brick_store.sv
// brick_store: DEPTH x STRENGTH_W brick strength array.
//   clk, reset          - clock, async active-high reset (read register only)
//   rd_idx / rd_data    - registered video lookup port (1 clk latency)
//   fill_we/idx/data    - wall rebuild write port (wins over hit)
//   hit_we/idx/data     - collision write port
module brick_store
  import brick_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned IDX_W = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [STRENGTH_W-1:0] rd_data,
  input  logic                  fill_we,
  input  logic [IDX_W-1:0]      fill_idx,
  input  logic [STRENGTH_W-1:0] fill_data,
  input  logic                  hit_we,
  input  logic [IDX_W-1:0]      hit_idx,
  input  logic [STRENGTH_W-1:0] hit_data
);

  logic [STRENGTH_W-1:0] mem [DEPTH];
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [STRENGTH_W-1:0] wr_data;

  always_comb begin
    wr_en   = fill_we | hit_we;
    wr_idx  = fill_we ? fill_idx  : hit_idx;
    wr_data = fill_we ? fill_data : hit_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/brick_field_engine.sv
// brick_field_engine: brick wall storage, video lookup, collision and refill control.
//   clk, reset        - pixel clock, async active-high reset
//   hpos, vpos        - beam position
//   vsync             - vertical sync level (synchronised internally)
//   ball_gfx          - ball pixel at the beam
//   refill            - rebuild the wall now
//   brick_present     - live brick under beam (2 clk lookup latency)
//   brick_gfx         - brick pixel with 1-px mortar gap
//   hit, kill         - collision / brick-destroyed pulses
//   level_clear       - last brick destroyed pulse
//   bricks_left       - live brick count
//   busy              - wall fill sweep in progress
// Configuration macro: BRICK_MULTIHIT_EN (see brick_pkg).
module brick_field_engine
  import brick_pkg::*;
#(
  parameter int unsigned BRICKS_H     = 16,
  parameter int unsigned BRICKS_V     = 8,
  parameter int unsigned BRICK_W_LOG2 = 4,
  parameter int unsigned BRICK_H_LOG2 = 3,
  parameter int unsigned FIELD_X      = 0,
  parameter int unsigned FIELD_Y      = 64
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [8:0]                                hpos,
  input  logic [8:0]                                vpos,
  input  logic                                      vsync,
  input  logic                                      ball_gfx,
  input  logic                                      refill,
  output logic                                      brick_present,
  output logic                                      brick_gfx,
  output logic                                      hit,
  output logic                                      kill,
  output logic                                      level_clear,
  output logic [$clog2(BRICKS_H*BRICKS_V+1)-1:0]    bricks_left,
  output logic                                      busy
);

  localparam int unsigned N     = BRICKS_H * BRICKS_V;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(N + 1);

  // Beam -> cell decode; negative offsets wrap high and fall outside the field.
  logic [8:0]       rel_x, rel_y, col, row;
  logic             in_field, mortar_ok;
  logic [IDX_W-1:0] cell_idx;

  always_comb begin
    rel_x     = hpos - 9'(FIELD_X);
    rel_y     = vpos - 9'(FIELD_Y);
    col       = rel_x >> BRICK_W_LOG2;
    row       = rel_y >> BRICK_H_LOG2;
    in_field  = (32'(col) < BRICKS_H) && (32'(row) < BRICKS_V);
    cell_idx  = in_field ? IDX_W'(32'(row) * BRICKS_H + 32'(col)) : '0;
    mortar_ok = (rel_y[BRICK_H_LOG2-1:0] != '0) && (rel_x[BRICK_W_LOG2-1:0] != '1);
  end

  // Stage 1 registers the index; stage 2 sits alongside the array read data.
  logic [IDX_W-1:0] idx_q, idx_q2;
  logic             in_field_q, in_field_q2, mortar_q, mortar_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      idx_q2      <= '0;
      in_field_q  <= 1'b0;
      in_field_q2 <= 1'b0;
      mortar_q    <= 1'b0;
      mortar_q2   <= 1'b0;
    end else begin
      idx_q       <= cell_idx;
      idx_q2      <= idx_q;
      in_field_q  <= in_field;
      in_field_q2 <= in_field_q;
      mortar_q    <= mortar_ok;
      mortar_q2   <= mortar_q;
    end
  end

  // vsync: two-flop synchroniser plus edge flop.
  logic vs_meta_q, vs_sync_q, vs_prev_q, vs_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      vs_meta_q <= vsync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
    end
  end

  assign vs_rise = vs_sync_q & ~vs_prev_q;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      fill_idx_q, fill_idx_d;
  logic [CNT_W-1:0]      bricks_left_q, bricks_left_d;
  logic                  hit_lock_q, hit_q, kill_q, level_clear_q, level_clear_d;
  logic [STRENGTH_W-1:0] rd_data, fill_data;
  logic                  fill_we, collision, last_step;

  assign busy          = (state_q == StFill);
  assign brick_present = in_field_q2 & (rd_data != '0) & ~busy;
  assign brick_gfx     = brick_present & mortar_q2;
  // refill pre-empts a same-cycle collision.
  assign collision     = ball_gfx & brick_gfx & (state_q == StPlay) & ~hit_lock_q & ~refill;
  assign last_step     = (rd_data == STRENGTH_W'(1));
  assign fill_data     = init_strength(32'(fill_idx_q) / BRICKS_H);

  always_comb begin
    state_d       = state_q;
    fill_idx_d    = fill_idx_q;
    bricks_left_d = bricks_left_q;
    level_clear_d = 1'b0;
    fill_we       = 1'b0;
    if (refill) begin
      state_d    = StFill;
      fill_idx_d = '0;
    end else begin
      unique case (state_q)
        StFill: begin
          fill_we = 1'b1;
          if (fill_idx_q == IDX_W'(N - 1)) begin
            state_d       = StPlay;
            fill_idx_d    = '0;
            bricks_left_d = CNT_W'(N);
          end else begin
            fill_idx_d = fill_idx_q + IDX_W'(1);
          end
        end
        StPlay: begin
          if (bricks_left_q == '0) begin
            state_d       = StCleared;
            level_clear_d = 1'b1;
          end else if (collision && last_step) begin
            bricks_left_d = bricks_left_q - CNT_W'(1);
          end
        end
        StCleared: begin
          if (vs_rise) begin
            state_d    = StFill;
            fill_idx_d = '0;
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StFill;
      fill_idx_q    <= '0;
      bricks_left_q <= '0;
      hit_lock_q    <= 1'b0;
      hit_q         <= 1'b0;
      kill_q        <= 1'b0;
      level_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_idx_q    <= fill_idx_d;
      bricks_left_q <= bricks_left_d;
      hit_q         <= collision;
      kill_q        <= collision & last_step;
      level_clear_q <= level_clear_d;
      if (collision) begin
        hit_lock_q <= 1'b1;
      end else if (vs_rise) begin
        hit_lock_q <= 1'b0;
      end
    end
  end

  assign hit         = hit_q;
  assign kill        = kill_q;
  assign level_clear = level_clear_q;
  assign bricks_left = bricks_left_q;

  brick_store #(
    .DEPTH (N),
    .IDX_W (IDX_W)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (idx_q),
    .rd_data   (rd_data),
    .fill_we   (fill_we),
    .fill_idx  (fill_idx_q),
    .fill_data (fill_data),
    .hit_we    (collision),
    .hit_idx   (idx_q2),
    .hit_data  (rd_data - STRENGTH_W'(1))
  );

endmodule

// File: tb/tb_brick_field_engine.sv
// Testbench for brick_field_engine: randomized ball strikes against a row/column strength
// model, with a scoreboard of expected hit events drained by an independent monitor.
module tb_brick_field_engine;

  localparam int BH = 16;
  localparam int BV = 8;
  localparam int N  = BH * BV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] hpos = '0, vpos = '0;
  logic       vsync = 1'b0, ball_gfx = 1'b0, refill = 1'b0;
  logic       brick_present, brick_gfx, hit, kill, level_clear, busy;
  logic [7:0] bricks_left;

  brick_field_engine dut (
    .clk           (clk),
    .reset         (reset),
    .hpos          (hpos),
    .vpos          (vpos),
    .vsync         (vsync),
    .ball_gfx      (ball_gfx),
    .refill        (refill),
    .brick_present (brick_present),
    .brick_gfx     (brick_gfx),
    .hit           (hit),
    .kill          (kill),
    .level_clear   (level_clear),
    .bricks_left   (bricks_left),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kill;
    int left;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0, n_pass = 0;
  int   hits_seen = 0, hits_exp = 0, kills_seen = 0, kills_exp = 0, lc_seen = 0, lc_exp = 0;
  bit   lc_due = 0;
  int   str_m [BV][BH];
  int   left_m;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int init_str(input int r);
`ifdef BRICK_MULTIHIT_EN
    return (r == 0) ? 3 : ((r < 3) ? 2 : 1);
`else
    return 1;
`endif
  endfunction

  task automatic model_rebuild();
    for (int r = 0; r < BV; r++)
      for (int c = 0; c < BH; c++) str_m[r][c] = init_str(r);
    left_m = N;
  endtask

  // Monitor: consumes expected hit events whenever the DUT pulses hit.
  always @(negedge clk) begin
    if (!reset) begin
      if (lc_due) begin
        check("level_clear_after_last_kill", int'(level_clear), 1);
        lc_due = 0;
      end
      if (level_clear) lc_seen++;
      if (kill) kills_seen++;
      if (hit) begin
        hits_seen++;
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("hit_kill", int'(kill), mon_e.kill);
          check("hit_bricks_left", int'(bricks_left), mon_e.left);
          if (mon_e.left == 0) lc_due = 1;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic place(input int r, input int c);
    hpos = 9'(c * 16 + int'($urandom_range(0, 14)));
    vpos = 9'(64 + r * 8 + int'($urandom_range(1, 7)));
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Counts clocks from the current point until busy drops.
  task automatic measure_fill(input string name);
    int cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      #1;
    end while (busy && cnt < 1000);
    check(name, cnt, N);
    check("bricks_left_after_fill", int'(bricks_left), N);
    model_rebuild();
    @(negedge clk);
  endtask

  task automatic probe(input int r, input int c);
    int live = (str_m[r][c] > 0) ? 1 : 0;
    ball_gfx = 1'b0;
    hpos = 9'd0;
    vpos = 9'd10;
    repeat (3) @(negedge clk);
    place(r, c);
    @(negedge clk);
    check("probe_latency_stage1", int'(brick_present), 0);
    @(negedge clk);
    check("probe_present", int'(brick_present), live);
    check("probe_gfx", int'(brick_gfx), live);
    hpos = 9'(c * 16 + 15);
    repeat (3) @(negedge clk);
    check("probe_xgap_present", int'(brick_present), live);
    check("probe_xgap_gfx", int'(brick_gfx), 0);
    hpos = 9'(c * 16 + 4);
    vpos = 9'(64 + r * 8);
    repeat (3) @(negedge clk);
    check("probe_ygap_gfx", int'(brick_gfx), 0);
  endtask

  task automatic attempt(input int r, input int c, input int len);
    int live, s, k;
    vsync_pulse();
    ball_gfx = 1'b0;
    place(r, c);
    repeat (3) @(negedge clk);
    live = (str_m[r][c] > 0) ? 1 : 0;
    if (live == 1) begin
      s = str_m[r][c] - 1;
      str_m[r][c] = s;
      k = (s == 0) ? 1 : 0;
      left_m -= k;
      exp_q.push_back('{kill: k, left: left_m});
      hits_exp++;
      kills_exp += k;
      if (left_m == 0) lc_exp++;
    end
    ball_gfx = 1'b1;
    @(negedge clk);
    check("hit_latency", int'(hit), live);
    for (int i = 1; i < len; i++) begin
      place(r, c);
      @(negedge clk);
    end
    ball_gfx = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int r, c, it, cnt, pick;
    int live_r[$], live_c[$];

    repeat (3) @(negedge clk);
    check("reset_brick_present", int'(brick_present), 0);
    check("reset_brick_gfx", int'(brick_gfx), 0);
    check("reset_hit", int'(hit), 0);
    check("reset_kill", int'(kill), 0);
    check("reset_level_clear", int'(level_clear), 0);
    check("reset_bricks_left", int'(bricks_left), 0);
    check("reset_busy", int'(busy), 1);
    reset = 1'b0;
    measure_fill("fill_after_reset");

    probe(0, 3);
    probe(5, 12);
    // Long overlap in a single frame must hit once; repeated frames wear the brick down.
    attempt(0, 3, 36);
    for (int i = 1; i < init_str(0); i++) attempt(0, 3, $urandom_range(2, 36));
    probe(0, 3);

    // Collision and refill in the same clock: refill wins.
    vsync_pulse();
    place(1, 7);
    repeat (3) @(negedge clk);
    ball_gfx = 1'b1;
    refill   = 1'b1;
    @(posedge clk);
    #1;
    ball_gfx = 1'b0;
    refill   = 1'b0;
    check("refill_no_hit", int'(hit), 0);
    check("refill_busy", int'(busy), 1);
    measure_fill("fill_after_refill");
    probe(0, 3);

    // Clear the whole wall with random strikes, occasionally aiming at any cell.
    it = 0;
    while (left_m > 0 && it < 2000) begin
      it++;
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, BV - 1);
        c = $urandom_range(0, BH - 1);
      end else begin
        live_r.delete();
        live_c.delete();
        for (int rr = 0; rr < BV; rr++)
          for (int cc = 0; cc < BH; cc++)
            if (str_m[rr][cc] > 0) begin
              live_r.push_back(rr);
              live_c.push_back(cc);
            end
        pick = $urandom_range(0, live_r.size() - 1);
        r = live_r[pick];
        c = live_c[pick];
      end
      attempt(r, c, $urandom_range(1, 36));
    end
    check("wall_cleared_by_model", left_m, 0);
    check("busy_in_cleared", int'(busy), 0);

    vsync = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      #1;
    end while (!busy && cnt < 20);
    check("vsync_to_fill_latency", cnt, 3);
    measure_fill("fill_after_clear");
    vsync = 1'b0;

    // Reset in the middle of a sweep.
    refill = 1'b1;
    @(posedge clk);
    #1;
    refill = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midfill_reset_busy", int'(busy), 1);
    check("midfill_reset_bricks_left", int'(bricks_left), 0);
    check("midfill_reset_hit", int'(hit), 0);
    check("midfill_reset_present", int'(brick_present), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    measure_fill("fill_after_midfill_reset");

    for (int i = 0; i < 20; i++)
      attempt($urandom_range(0, BV - 1), $urandom_range(0, BH - 1), $urandom_range(1, 36));
    probe($urandom_range(0, 2), $urandom_range(0, BH - 1));

    repeat (10) @(negedge clk);
    check("total_hits", hits_seen, hits_exp);
    check("total_kills", kills_seen, kills_exp);
    check("total_level_clears", lc_seen, lc_exp);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
